mux2_1: RTL and testbench
=========================

# mux2_1

Registered, parameterizable 2:1 multiplexer used as a selectable datapath stage. It picks operand `a` or `b` under control of `sel` and presents the result one clock later with a valid flag. An optional saturating counter tracks how often the accepted select value changes, for debug and coverage. The block sits between operand sources and downstream consumers that expect a single-cycle-registered datapath.

## Interface
Module name: `mux2_1`. One clock; reset is synchronous and active-low.

Parameters:
- `WIDTH`, default 1: data width of `a`, `b` and `out`.
- `CNT_W`, default 8: width of `switch_cnt`.

Ports:
- `clk`  input  1: clock; all state updates on the rising edge.
- `rst_n`  input  1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `a`  input  WIDTH: operand selected when `sel`=1.
- `b`  input  WIDTH: operand selected when `sel`=0.
- `sel`  input  1: select; 1 picks `a`, 0 picks `b`.
- `in_valid`  input  1: qualifies `a`, `b` and `sel` this cycle.
- `out`  output  WIDTH: registered mux result.
- `out_valid`  output  1: `out` holds a result accepted on the previous edge.
- `sel_q`  output  1: last accepted `sel` value.
- `switch_cnt`  output  CNT_W: count of accepted `sel` changes. Present only with the macro; see Configuration.

## Operation
- Accept: on a rising edge with `rst_n`=1 and `in_valid`=1:
  - `out` <= `sel` ? `a` : `b`
  - `sel_q` <= `sel`
  - `out_valid` <= 1
- Idle: on a rising edge with `rst_n`=1 and `in_valid`=0:
  - `out` and `sel_q` hold their values.
  - `out_valid` <= 0
- No backpressure. Every valid input is accepted, and there is no ready signal.
- The selection is bitwise across all WIDTH bits. There is no arithmetic and no width conversion.
- `sel` must be 0 or 1 when `in_valid`=1. An X/Z on `sel` is an input protocol violation, and the bench flags it.
- Select-change detection: an accept where `sel` != `sel_q` counts as a switch.
  - The first accept after reset compares against the reset value of `sel_q`, which is 0.

## Timing
- Latency is exactly 1 cycle from an accepting edge to the new `out`/`out_valid`.
- Throughput is one result per cycle. Back-to-back `in_valid` produces continuous `out_valid`.
- Reset values:
  - `out` = 0
  - `out_valid` = 0
  - `sel_q` = 0
  - `switch_cnt` = 0
- Reset takes priority over `in_valid` on the same edge.
- Reset asserted mid-stream discards the in-flight input. `out_valid` is 0 on the cycle after reset.
- Changes on `a`/`b`/`sel` between edges have no effect on outputs. There is no combinational path from any input to any output.

## Configuration
- Macro `MUX2_1_SWITCH_CNT_EN`.
- Defined:
  - `switch_cnt` port and counter logic are compiled in.
  - The counter increments by 1 on each accepted select change and saturates at 2^CNT_W-1. It never wraps.
  - It is cleared only by reset.
- Undefined:
  - The `switch_cnt` port and counter logic are absent.
  - All other behaviour is identical.

## Test plan
- Reset: hold `rst_n`=0 for 2 cycles with `in_valid`=1, `a`=1, `b`=0, `sel`=1 -> `out`=0, `out_valid`=0, `sel_q`=0, `switch_cnt`=0.
- Basic select: release reset with `a`=1, `b`=0, `sel`=1, `in_valid`=1 -> one cycle later `out`=1, `out_valid`=1. Then `sel`=0 -> next cycle `out`=0.
- Hold: WIDTH=8, accept `a`=8'hA5 with `sel`=1, then `in_valid`=0 for 3 cycles while `a` and `b` toggle -> `out` stays 8'hA5 and `out_valid`=0 during the idle cycles.
- Streaming: 16 back-to-back accepts with random `a`/`b`/`sel` -> each `out` equals the model result of the previous cycle, and `out_valid` stays at 1 throughout.
- Counter (macro defined, CNT_W=2): alternate `sel` 1,0,1,0,1 on accepts -> `switch_cnt` steps 1,2,3,3,3 (saturation). A `sel` change with `in_valid`=0 does not count.
- Reset mid-stream: assert `rst_n`=0 on a cycle with `in_valid`=1, `sel`=1 -> next cycle `out`=0, `out_valid`=0, `switch_cnt`=0.

Source files
------------

// File: rtl/mux2_1.sv
`default_nettype none
// ============================================================================
//  Module   : mux2_1
//  Purpose  : Registered WIDTH-bit 2:1 multiplexer stage with a valid flag.
//             sel=1 picks a, sel=0 picks b. The result appears one cycle
//             after the accepting edge. No backpressure.
//             Optional saturating select-switch counter, enabled by the
//             MUX2_1_SWITCH_CNT_EN macro.
//  Revision : 1.0 - initial release
// ============================================================================
module mux2_1 #(
   parameter int WIDTH = 1,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sel,
   input  logic             in_valid,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             sel_q
`ifdef MUX2_1_SWITCH_CNT_EN
   ,
   output logic [CNT_W-1:0] switch_cnt
`endif
);

   logic [WIDTH-1:0] r_out;
   logic             r_out_valid;
   logic             r_sel_q;

   // Datapath register: load the selected operand on accept, hold otherwise
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out   <= '0;
         r_sel_q <= 1'b0;
      end else if (in_valid) begin
         r_out   <= sel ? a : b;
         r_sel_q <= sel;
      end
   end

   // Valid flag follows the accept of the previous edge; idle cycles clear it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
      end
   end

   assign out       = r_out;
   assign out_valid = r_out_valid;
   assign sel_q     = r_sel_q;

`ifdef MUX2_1_SWITCH_CNT_EN
   localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

   logic             w_switch;
   logic [CNT_W-1:0] r_switch_cnt;

   // A switch is an accepted select that differs from the last accepted one
   // (reset value of sel_q is 0, so the first accept compares against 0)
   assign w_switch = in_valid && (sel != r_sel_q);

   // Saturating switch counter, cleared only by reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_switch_cnt <= '0;
      end else if (w_switch && (r_switch_cnt != c_CNT_MAX)) begin
         r_switch_cnt <= r_switch_cnt + 1'b1;
      end
   end

   assign switch_cnt = r_switch_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mux2_1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux2_1
//  Purpose  : Self-checking bench for mux2_1 (WIDTH=8, CNT_W=2), randomized
//             stimulus against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux2_1;

   localparam int WIDTH = 8;
   localparam int CNT_W = 2;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             sel;
   logic             in_valid;
   logic [WIDTH-1:0] out;
   logic             out_valid;
   logic             sel_q;
`ifdef MUX2_1_SWITCH_CNT_EN
   logic [CNT_W-1:0] switch_cnt;
`endif

   mux2_1 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .a          (a),
      .b          (b),
      .sel        (sel),
      .in_valid   (in_valid),
      .out        (out),
      .out_valid  (out_valid),
      .sel_q      (sel_q)
`ifdef MUX2_1_SWITCH_CNT_EN
      ,
      .switch_cnt (switch_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: the last accepted transaction and a running switch tally
   logic [WIDTH-1:0] m_out;
   logic             m_valid;
   logic             m_sel;
   int               m_switches;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"},       32'(out),       32'(m_out));
      check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
      check({tag, ".sel_q"},     32'(sel_q),     32'(m_sel));
`ifdef MUX2_1_SWITCH_CNT_EN
      check({tag, ".switch_cnt"}, 32'(switch_cnt),
            32'((m_switches > CNT_MAX) ? CNT_MAX : m_switches));
`endif
   endtask

   // Apply one cycle of inputs, advance the model on the edge, check after it
   task automatic step(input string tag, input logic r, input logic v, input logic s,
                       input logic [WIDTH-1:0] da, input logic [WIDTH-1:0] db);
      rst_n    = r;
      in_valid = v;
      sel      = s;
      a        = da;
      b        = db;
      if (v)
         check({tag, ".sel_known"}, 32'($isunknown(sel)), 32'd0);
      @(posedge clk);
      if (!r) begin
         m_out = '0; m_valid = 1'b0; m_sel = 1'b0; m_switches = 0;
      end else if (v) begin
         if (s != m_sel) m_switches++;
         m_out   = s ? da : db;
         m_sel   = s;
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      #1;
      check_all(tag);
      // Inputs wiggling between edges must not reach the outputs
      a = WIDTH'($urandom);
      b = WIDTH'($urandom);
      sel = ~sel;
      #3;
      check_all({tag, ".mid"});
   endtask

   initial begin
      m_out = '0; m_valid = 1'b0; m_sel = 1'b0; m_switches = 0;
      rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; a = '0; b = '0;
      #2;

      // Reset held with an active input
      step("reset0", 1'b0, 1'b1, 1'b1, 8'h01, 8'h00);
      step("reset1", 1'b0, 1'b1, 1'b1, 8'h01, 8'h00);

      // Basic select
      step("basic_a", 1'b1, 1'b1, 1'b1, 8'h01, 8'h00);
      step("basic_b", 1'b1, 1'b1, 1'b0, 8'h01, 8'h00);

      // Hold during idle cycles
      step("hold_ld", 1'b1, 1'b1, 1'b1, 8'hA5, 8'h5A);
      for (int i = 0; i < 3; i++)
         step("hold", 1'b1, 1'b0, 1'($urandom), WIDTH'($urandom), WIDTH'($urandom));

      // Counter pattern from a clean reset, then a select change while idle
      step("cnt_rst", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 5; i++)
         step("cnt", 1'b1, 1'b1, 1'((i + 1) % 2), WIDTH'($urandom), WIDTH'($urandom));
      step("cnt_idle", 1'b1, 1'b0, 1'b0, WIDTH'($urandom), WIDTH'($urandom));

      // Streaming: 16 back-to-back accepts
      step("strm_rst", 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 16; i++)
         step("stream", 1'b1, 1'b1, 1'($urandom), WIDTH'($urandom), WIDTH'($urandom));

      // Reset mid-stream discards the in-flight input
      step("mid_rst", 1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF);

      // Mixed random traffic with occasional resets
      for (int i = 0; i < 60; i++)
         step("rand", ($urandom_range(0, 19) != 0), 1'($urandom), 1'($urandom),
              WIDTH'($urandom), WIDTH'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
